// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: converts a signed 8-bit PID controller output into a complementary,
// dead-time protected PWM gate drive with a 256-cycle period.
//
// Parameters
//   DEAD      dead-time in clk cycles (1..15) between one gate turning off and the other on
//   DUTY_MIN  lowest permitted duty code
//   DUTY_MAX  highest permitted duty code
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset; gates go low immediately
//   en           run enable; 0 forces both gates off and parks the period counter
//   u_in         signed controller output
//   u_valid      single-cycle qualifier for u_in
//   pwm_h        high-side gate drive
//   pwm_l        low-side gate drive
//   sample_tick  one-cycle pulse in the first cycle (cnt=0) of each period
//   duty_q       duty code active in the current period
module pid_pwm_driver #(
    parameter int unsigned DEAD     = 2,
    parameter int unsigned DUTY_MIN = 8,
    parameter int unsigned DUTY_MAX = 247
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic signed [7:0] u_in,
    input  logic              u_valid,
    output logic              pwm_h,
    output logic              pwm_l,
    output logic              sample_tick,
    output logic        [7:0] duty_q
);

    localparam logic [7:0] DutyMin  = 8'(DUTY_MIN);
    localparam logic [7:0] DutyMax  = 8'(DUTY_MAX);
    localparam logic [3:0] DeadLoad = 4'(DEAD - 1);

    typedef enum logic [2:0] {
        StSafe,
        StHigh,
        StDtToLow,
        StLow,
        StDtToHigh
    } state_e;

    logic [7:0] code;
    logic [7:0] code_clamped;
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] duty_d;
    logic       tick_d;
    logic       run_q;
    logic       raw_h;
    state_e     state_q, state_d;
    logic [3:0] dt_q, dt_d;

    // Offset binary: adding 128 to a two's-complement byte just flips the sign bit.
    assign code = {~u_in[7], u_in[6:0]};

    always_comb begin
        code_clamped = code;
        if (code < DutyMin) begin
            code_clamped = DutyMin;
        end else if (code > DutyMax) begin
            code_clamped = DutyMax;
        end
    end

    // Shadow keeps tracking u_valid even while disabled.
    assign shadow_d = u_valid ? code_clamped : shadow_q;

    // Period counter and duty reload. run_q is en from the previous cycle, so
    // en & ~run_q marks the first enabled edge. Using shadow_d at the reload gives
    // the bypass when u_valid lands on cnt=255.
    always_comb begin
        cnt_d  = cnt_q;
        duty_d = duty_q;
        tick_d = 1'b0;
        if (!en) begin
            cnt_d = 8'd0;
        end else if (!run_q) begin
            cnt_d  = 8'd0;
            duty_d = shadow_d;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'hff) begin
                duty_d = shadow_d;
                tick_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 8'd0;
            duty_q      <= 8'd128;
            shadow_q    <= 8'd128;
            run_q       <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            shadow_q    <= shadow_d;
            run_q       <= en;
            sample_tick <= tick_d;
        end
    end

    assign raw_h = (cnt_q < duty_q);

    // Gate FSM. SAFE waits for the first running cycle (run_q) so the dead-time
    // starts from cnt=0 with the freshly loaded duty, exactly like a period wrap.
    always_comb begin
        state_d = state_q;
        dt_d    = dt_q;
        if (!en) begin
            state_d = StSafe;
            dt_d    = 4'd0;
        end else begin
            unique case (state_q)
                StSafe: begin
                    if (run_q) begin
                        state_d = raw_h ? StDtToHigh : StDtToLow;
                        dt_d    = DeadLoad;
                    end
                end
                StHigh: begin
                    if (!raw_h) begin
                        state_d = StDtToLow;
                        dt_d    = DeadLoad;
                    end
                end
                StLow: begin
                    if (raw_h) begin
                        state_d = StDtToHigh;
                        dt_d    = DeadLoad;
                    end
                end
                StDtToLow: begin
                    if (raw_h) begin
                        // Demand reverted: retarget and restart the dead-time.
                        state_d = StDtToHigh;
                        dt_d    = DeadLoad;
                    end else if (dt_q == 4'd0) begin
                        state_d = StLow;
                    end else begin
                        dt_d = dt_q - 4'd1;
                    end
                end
                StDtToHigh: begin
                    if (!raw_h) begin
                        state_d = StDtToLow;
                        dt_d    = DeadLoad;
                    end else if (dt_q == 4'd0) begin
                        state_d = StHigh;
                    end else begin
                        dt_d = dt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = StSafe;
                    dt_d    = 4'd0;
                end
            endcase
        end
    end

    // Gate outputs are decoded from the next state and registered, so each gate
    // is a flop output that can only be high in its own drive state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSafe;
            dt_q    <= 4'd0;
            pwm_h   <= 1'b0;
            pwm_l   <= 1'b0;
        end else begin
            state_q <= state_d;
            dt_q    <= dt_d;
            pwm_h   <= (state_d == StHigh);
            pwm_l   <= (state_d == StLow);
        end
    end

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Bench for pid_pwm_driver: directed stimulus pushes the expected duty code for
// each upcoming period into a queue; a negedge monitor pops it on every
// sample_tick and also checks per-period high time and dead-time gaps.
module tb_pid_pwm_driver;

    localparam int DEAD = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic signed [7:0] u_in;
    logic              u_valid;
    logic              pwm_h;
    logic              pwm_l;
    logic              sample_tick;
    logic        [7:0] duty_q;

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];

    // Monitor state
    int hi_cnt    = 0;
    int exp_hi    = 0;
    bit hi_pend   = 1'b0;
    int gap       = 0;
    int last_gate = 0;
    int prev_cur  = 0;
    int cur       = 0;
    int e         = 0;

    always #5 clk = ~clk;

    pid_pwm_driver #(
        .DEAD     (DEAD),
        .DUTY_MIN (8),
        .DUTY_MAX (247)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .u_in        (u_in),
        .u_valid     (u_valid),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .sample_tick (sample_tick),
        .duty_q      (duty_q)
    );

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int v);
        u_in    = 8'(v);
        u_valid = 1'b1;
        step();
        u_valid = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        step();
        while (!sample_tick && n < 300) begin
            step();
            n++;
        end
        chk("tick_seen", int'(sample_tick), 1);
    endtask

    // Gates must never overlap.
    always @(negedge clk) begin
        assert (!(pwm_h && pwm_l)) else begin
            n_total++;
            $display("FAIL overlap: pwm_h=%0b pwm_l=%0b, required not both 1", pwm_h, pwm_l);
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst || !en) begin
            hi_pend   = 1'b0;
            last_gate = 0;
            prev_cur  = 0;
            gap       = 0;
        end else begin
            if (sample_tick) begin
                if (hi_pend) chk("high_cycles", hi_cnt, exp_hi);
                chk("tick_queue_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("duty_at_tick", int'(duty_q), e);
                    exp_hi  = e - DEAD;
                    hi_pend = 1'b1;
                end else begin
                    hi_pend = 1'b0;
                end
                hi_cnt = 0;
            end
            if (pwm_h) hi_cnt++;
            cur = pwm_h ? 1 : (pwm_l ? 2 : 0);
            if (cur != 0) begin
                if (prev_cur == 0 && last_gate != 0 && last_gate != cur)
                    chk("dead_gap", gap, DEAD);
                last_gate = cur;
                gap       = 0;
            end else begin
                gap++;
            end
            prev_cur = cur;
        end
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        u_valid = 1'b0;
        u_in    = 8'sd0;
        repeat (3) step();
        chk("rst_pwm_h", int'(pwm_h), 0);
        chk("rst_pwm_l", int'(pwm_l), 0);
        chk("rst_tick", int'(sample_tick), 0);
        chk("rst_duty", int'(duty_q), 128);
        rst = 1'b0;
        repeat (2) step();
        chk("idle_tick", int'(sample_tick), 0);

        // Enable with u_in=0 -> duty 128
        en = 1'b1;
        exp_q.push_back(128);
        pulse(0);
        chk("en_rise_tick", int'(sample_tick), 1);
        chk("duty_p1", int'(duty_q), 128);
        chk("start_safe", int'(pwm_h | pwm_l), 0);

        // Max clamp, visible only next period
        repeat (10) step();
        exp_q.push_back(247);
        pulse(127);
        repeat (5) step();
        chk("duty_hold_128", int'(duty_q), 128);
        wait_tick();

        // Min clamp
        repeat (10) step();
        exp_q.push_back(8);
        pulse(-128);
        repeat (5) step();
        chk("duty_hold_247", int'(duty_q), 247);
        wait_tick();
        chk("duty_p3", int'(duty_q), 8);

        // Bypass: u_valid on cnt=255
        repeat (255) step();
        exp_q.push_back(192);
        pulse(64);
        chk("bypass_tick", int'(sample_tick), 1);
        chk("bypass_duty", int'(duty_q), 192);

        // Drop en mid-HIGH, update shadow while disabled, re-enable
        repeat (100) step();
        chk("mid_high", int'(pwm_h), 1);
        en = 1'b0;
        step();
        chk("drop_pwm_h", int'(pwm_h), 0);
        chk("drop_pwm_l", int'(pwm_l), 0);
        chk("drop_cnt", int'(dut.cnt_q), 0);
        chk("drop_tick", int'(sample_tick), 0);
        repeat (3) step();
        pulse(-100);
        repeat (3) step();
        chk("disabled_duty_holds", int'(duty_q), 192);
        chk("disabled_gates", int'(pwm_h | pwm_l), 0);
        en = 1'b1;
        exp_q.push_back(28);
        step();
        chk("reen_tick", int'(sample_tick), 1);
        chk("reen_duty", int'(duty_q), 28);
        chk("reen_safe", int'(pwm_h | pwm_l), 0);
        step();
        chk("reen_dt1", int'(pwm_h | pwm_l), 0);
        step();
        chk("reen_dt2", int'(pwm_h | pwm_l), 0);
        step();
        chk("reen_high", int'(pwm_h), 1);
        exp_q.push_back(28);
        wait_tick();

        // Async reset between edges while low side is on
        repeat (100) step();
        chk("mid_low", int'(pwm_l), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_l", int'(pwm_l), 0);
        chk("async_rst_h", int'(pwm_h), 0);
        chk("async_rst_duty", int'(duty_q), 128);
        en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_duty", int'(duty_q), 128);
        chk("post_rst_tick", int'(sample_tick), 0);
        chk("post_rst_gates", int'(pwm_h | pwm_l), 0);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pid_pwm_driver.md
PID_PWM_DRIVER -- requirements
Module: pid_pwm_driver

Interface
REQ-001 SHALL have parameter DEAD, default 2, meaning dead-time in clk cycles (1..15).
REQ-002 SHALL have parameter DUTY_MIN, default 8, meaning lowest permitted duty code.
REQ-003 SHALL have parameter DUTY_MAX, default 247, meaning highest permitted duty code.
REQ-004 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: run enable; 0 forces outputs safe.
REQ-007 SHALL have port u_in, input, signed 8 bits: controller output from the PID stage.
REQ-008 SHALL have port u_valid, input, 1 bit: u_in qualifier, single-cycle strobe.
REQ-009 SHALL have port pwm_h, output, 1 bit: high-side gate drive.
REQ-010 SHALL have port pwm_l, output, 1 bit: low-side gate drive, complementary to pwm_h.
REQ-011 SHALL have port sample_tick, output, 1 bit: one-cycle pulse at period start; used as the PID stage's update enable.
REQ-012 SHALL have port duty_q, output, 8 bits unsigned: duty code active in the current period.

Function
REQ-013 SHALL convert u_in to an offset-binary code: u_in + 128, giving 0..255 (-128 maps to 0, 0 maps to 128, 127 maps to 255).
REQ-014 SHALL clamp the converted code into the range [DUTY_MIN, DUTY_MAX] before storing it.
REQ-015 SHALL store the clamped code into a shadow register only when u_valid=1; otherwise the shadow register holds its value.
REQ-016 SHALL run an 8-bit period counter cnt that increments every cycle while en=1 and wraps from 255 to 0 (period = 256 cycles).
REQ-017 SHALL load duty_q from the shadow register on the cycle cnt wraps from 255 to 0.
REQ-018 SHALL, if u_valid coincides with cnt=255, load the new clamped code into both duty_q and the shadow register at that wrap (bypass).
REQ-019 SHALL assert sample_tick for exactly one cycle, in the cycle where cnt=0, while en=1.
REQ-020 SHALL compute the raw demand raw_h = (cnt < duty_q).
REQ-021 SHALL implement a gate FSM with states SAFE, HIGH, DT_TO_LOW, LOW and DT_TO_HIGH.
REQ-022 SHALL drive outputs by state: HIGH gives pwm_h=1, pwm_l=0; LOW gives pwm_h=0, pwm_l=1; SAFE and both DT states give pwm_h=0, pwm_l=0.
REQ-023 SHALL transition HIGH to DT_TO_LOW when raw_h=0, and LOW to DT_TO_HIGH when raw_h=1.
REQ-024 SHALL hold a DT state for exactly DEAD cycles, then enter the state matching the current raw_h.
REQ-025 SHALL, if raw_h reverts during a DT state, retarget that DT state and restart the dead-time count.
REQ-026 SHALL never drive pwm_h=1 and pwm_l=1 in the same cycle, in any state or input sequence.
REQ-027 SHALL register the FSM outputs, giving 1 cycle latency from a raw_h change to the DT entry.
REQ-028 SHALL, when en=0: force state SAFE, hold cnt=0, hold sample_tick=0, and keep the shadow register updating on u_valid.
REQ-029 SHALL, on an en 0-to-1 transition: load duty_q from the shadow register, set cnt=0, assert sample_tick, and go SAFE to DT_TO_HIGH or DT_TO_LOW according to raw_h.

Reset
REQ-030 SHALL, on rst=1 (asynchronous), set state=SAFE, pwm_h=0, pwm_l=0, cnt=0, sample_tick=0, and dead-time count=0.
REQ-031 SHALL, on rst=1, set the shadow register and duty_q to 128 (50% duty).
REQ-032 SHALL, on rst asserted mid-period or mid-dead-time, drive both gates low immediately, without waiting for a clock edge.

Verification
REQ-033 Scenario: rst, then en=1, u_in=0 with u_valid -> duty_q=128; pwm_h high for 128-DEAD cycles per 256; sample_tick every 256 cycles.
REQ-034 Scenario: u_in=127, then u_in=-128 -> duty_q=247, then 8 (clamped); change becomes visible only at the next cnt=0.
REQ-035 Scenario: u_valid with u_in=64 at cnt=255 -> duty_q=192 in the very next period (bypass).
REQ-036 Scenario: every HIGH/LOW edge -> both gates low for exactly 2 cycles; an assertion checks pwm_h and pwm_l never both 1.
REQ-037 Scenario: en dropped mid-HIGH -> both gates 0 next cycle, cnt=0; on en re-raised -> sample_tick in the same cycle, dead-time then the drive.
REQ-038 Scenario: rst pulsed between clock edges while pwm_l=1 -> pwm_l=0 asynchronously; duty_q=128 after release.
